// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-requester memory arbiter:
//   - default memory geometry (2048 x 8)
//   - FSM state encoding (CLEAR sweep / RUN)
//   - requester identifiers used by the round-robin pointer and read tags
//   - layout of the read-return tag carried alongside each issued access
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int MEM_ADDR_W = 11;
    localparam int MEM_DATA_W = 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    // One tag per issued access; it travels two stages so the read data can
    // be steered back to whoever issued the read.
    typedef struct packed {
        logic isRead;
        logic id;
    } tag_t;

    localparam tag_t TAG_EMPTY = '{isRead: 1'b0, id: ID_A};

endpackage

// File: rtl/mem_arb_rr.sv
// ---------------------------------------------------------------------------
// mem_arb_rr
// Two-way round-robin picker. Purely combinational.
// Ports:
//   i_reqA, i_reqB  : qualified requests from A and B
//   i_rrPtr         : requester favoured when both request (ID_A / ID_B)
//   o_grantA/B      : one-hot (or zero) grant
//   o_nextPtr       : pointer value after this cycle (other side after a grant,
//                     unchanged when idle)
// ---------------------------------------------------------------------------
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic i_reqA,
    input  logic i_reqB,
    input  logic i_rrPtr,
    output logic o_grantA,
    output logic o_grantB,
    output logic o_nextPtr
);

    // A wins when it is the only requester or when the pointer names it;
    // otherwise B wins whenever it asks.
    always_comb begin
        o_grantA  = 1'b0;
        o_grantB  = 1'b0;
        o_nextPtr = i_rrPtr;
        if (i_reqA && (!i_reqB || (i_rrPtr == ID_A))) begin
            o_grantA = 1'b1;
        end else if (i_reqB) begin
            o_grantB = 1'b1;
        end
        if (o_grantA) begin
            o_nextPtr = ID_B;
        end else if (o_grantB) begin
            o_nextPtr = ID_A;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Controller for a single-port RAM shared by two requesters (A and B).
// After reset it optionally sweeps CLEAR_VALUE into every address, then
// arbitrates round-robin between A and B using a valid/ack handshake.
// Memory pins are driven from registers; read data returns two cycles after
// the handshake edge as a one-cycle VALID strobe to the issuing requester.
//
// Ports:
//   CLK, RST_N                  clock, asynchronous active-low reset
//   A_REQ/A_WE/A_ADDRESS/A_DI   requester A access (held until A_ACK)
//   A_ACK                       combinational grant for A this cycle
//   A_DO/A_VALID                read return for A
//   B_*                         identical set for requester B
//   MEM_EN/MEM_WE/MEM_ADDRESS/MEM_DI/MEM_DO   RAM interface
//   INIT_DONE                   high once the arbiter is in RUN
//
// Optional build macro MEM_ARB_STATS_EN adds A_GRANT_CNT / B_GRANT_CNT,
// saturating per-requester handshake counters.
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int                ADDR_W         = MEM_ADDR_W,
    parameter int                DATA_W         = MEM_DATA_W,
    parameter int                CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              A_REQ,
    input  logic              A_WE,
    input  logic [ADDR_W-1:0] A_ADDRESS,
    input  logic [DATA_W-1:0] A_DI,
    output logic              A_ACK,
    output logic [DATA_W-1:0] A_DO,
    output logic              A_VALID,
    input  logic              B_REQ,
    input  logic              B_WE,
    input  logic [ADDR_W-1:0] B_ADDRESS,
    input  logic [DATA_W-1:0] B_DI,
    output logic              B_ACK,
    output logic [DATA_W-1:0] B_DO,
    output logic              B_VALID,
    output logic              MEM_EN,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDRESS,
    output logic [DATA_W-1:0] MEM_DI,
    input  logic [DATA_W-1:0] MEM_DO,
    output logic              INIT_DONE
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]       A_GRANT_CNT,
    output logic [15:0]       B_GRANT_CNT
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR   = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam state_t            RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W-1:0] r_clrAddr;
    logic              r_rrPtr;
    logic              r_initDone;

    logic              r_memEn;
    logic              r_memWe;
    logic [ADDR_W-1:0] r_memAddr;
    logic [DATA_W-1:0] r_memDi;

    tag_t              r_tag0;
    tag_t              r_tag1;

    logic [DATA_W-1:0] r_aDo;
    logic              r_aValid;
    logic [DATA_W-1:0] r_bDo;
    logic              r_bValid;

    logic              w_runActive;
    logic              w_reqA;
    logic              w_reqB;
    logic              w_grantA;
    logic              w_grantB;
    logic              w_nextPtr;
    logic              w_issue;
    logic              w_issueWe;
    logic [ADDR_W-1:0] w_issueAddr;
    logic [DATA_W-1:0] w_issueDi;
    logic              w_issueId;

    // State register: CLEAR or RUN depending on whether the sweep is enabled.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: leave CLEAR in the same cycle that issues the last address,
    // so the sweep is exactly 2^ADDR_W writes with no repeat.
    always_comb begin
        w_nextState = r_state;
        if ((r_state == ST_CLEAR) && (r_clrAddr == LAST_ADDR)) begin
            w_nextState = ST_RUN;
        end
    end

    // Requests are only honoured in RUN. INIT_DONE is also required so that
    // no grant can appear while reset is held with the sweep disabled.
    always_comb begin
        w_runActive = (r_state == ST_RUN) && r_initDone;
        w_reqA      = A_REQ && w_runActive;
        w_reqB      = B_REQ && w_runActive;
    end

    mem_arb_rr u_rr (
        .i_reqA   (w_reqA),
        .i_reqB   (w_reqB),
        .i_rrPtr  (r_rrPtr),
        .o_grantA (w_grantA),
        .o_grantB (w_grantB),
        .o_nextPtr(w_nextPtr)
    );

    // Output/issue decode: select the granted requester's fields.
    always_comb begin
        w_issue     = w_grantA || w_grantB;
        w_issueId   = w_grantB ? ID_B : ID_A;
        w_issueWe   = w_grantB ? B_WE : A_WE;
        w_issueAddr = w_grantB ? B_ADDRESS : A_ADDRESS;
        w_issueDi   = w_grantB ? B_DI : A_DI;
    end

    assign A_ACK = w_grantA;
    assign B_ACK = w_grantB;

    // Sweep address, round-robin pointer and INIT_DONE.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_clrAddr  <= '0;
            r_rrPtr    <= ID_A;
            r_initDone <= 1'b0;
        end else begin
            if (r_state == ST_CLEAR) begin
                r_clrAddr <= r_clrAddr + ADDR_ONE;
            end
            r_rrPtr    <= w_nextPtr;
            r_initDone <= (w_nextState == ST_RUN);
        end
    end

    // Memory pins: sweep writes in CLEAR, granted access in RUN. When idle
    // only EN/WE drop; address and data hold to avoid needless toggling.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_memEn   <= 1'b0;
            r_memWe   <= 1'b0;
            r_memAddr <= '0;
            r_memDi   <= '0;
        end else if (r_state == ST_CLEAR) begin
            r_memEn   <= 1'b1;
            r_memWe   <= 1'b1;
            r_memAddr <= r_clrAddr;
            r_memDi   <= CLEAR_VALUE;
        end else if (w_issue) begin
            r_memEn   <= 1'b1;
            r_memWe   <= w_issueWe;
            r_memAddr <= w_issueAddr;
            r_memDi   <= w_issueDi;
        end else begin
            r_memEn   <= 1'b0;
            r_memWe   <= 1'b0;
        end
    end

    // Tag pipeline: stage 0 lines up with the access on the pins, stage 1
    // with the cycle in which the RAM presents DO.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_tag0 <= TAG_EMPTY;
            r_tag1 <= TAG_EMPTY;
        end else begin
            r_tag0 <= w_issue ? '{isRead: !w_issueWe, id: w_issueId} : TAG_EMPTY;
            r_tag1 <= r_tag0;
        end
    end

    // Read return: capture DO for the tagged requester; DO holds otherwise.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_aDo    <= '0;
            r_aValid <= 1'b0;
            r_bDo    <= '0;
            r_bValid <= 1'b0;
        end else begin
            r_aValid <= r_tag1.isRead && (r_tag1.id == ID_A);
            r_bValid <= r_tag1.isRead && (r_tag1.id == ID_B);
            if (r_tag1.isRead && (r_tag1.id == ID_A)) begin
                r_aDo <= MEM_DO;
            end
            if (r_tag1.isRead && (r_tag1.id == ID_B)) begin
                r_bDo <= MEM_DO;
            end
        end
    end

    assign MEM_EN      = r_memEn;
    assign MEM_WE      = r_memWe;
    assign MEM_ADDRESS = r_memAddr;
    assign MEM_DI      = r_memDi;
    assign A_DO        = r_aDo;
    assign A_VALID     = r_aValid;
    assign B_DO        = r_bDo;
    assign B_VALID     = r_bValid;
    assign INIT_DONE   = r_initDone;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] r_aGrantCnt;
    logic [15:0] r_bGrantCnt;

    // Saturating handshake counters; sweep writes never raise a grant.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_aGrantCnt <= '0;
            r_bGrantCnt <= '0;
        end else begin
            if (w_grantA && (r_aGrantCnt != 16'hFFFF)) begin
                r_aGrantCnt <= r_aGrantCnt + 16'd1;
            end
            if (w_grantB && (r_bGrantCnt != 16'hFFFF)) begin
                r_bGrantCnt <= r_bGrantCnt + 16'd1;
            end
        end
    end

    assign A_GRANT_CNT = r_aGrantCnt;
    assign B_GRANT_CNT = r_bGrantCnt;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed testbench for mem_arbiter with a behavioural 2048x8 RAM attached
// to the memory pins. Expected values are hand-computed per scenario.
// Build with MEM_ARB_STATS_EN defined to also exercise the grant counters.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk;
    logic        rstN;
    logic        aReq, aWe, bReq, bWe;
    logic [10:0] aAddr, bAddr;
    logic [7:0]  aDi, bDi;
    logic        aAck, aValid, bAck, bValid;
    logic [7:0]  aDo, bDo;
    logic        memEn, memWe;
    logic [10:0] memAddr;
    logic [7:0]  memDi;
    logic [7:0]  memDo;
    logic        initDone;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] aGrantCnt, bGrantCnt;
`endif

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] ram [2048];

    mem_arbiter dut (
        .CLK        (clk),
        .RST_N      (rstN),
        .A_REQ      (aReq),
        .A_WE       (aWe),
        .A_ADDRESS  (aAddr),
        .A_DI       (aDi),
        .A_ACK      (aAck),
        .A_DO       (aDo),
        .A_VALID    (aValid),
        .B_REQ      (bReq),
        .B_WE       (bWe),
        .B_ADDRESS  (bAddr),
        .B_DI       (bDi),
        .B_ACK      (bAck),
        .B_DO       (bDo),
        .B_VALID    (bValid),
        .MEM_EN     (memEn),
        .MEM_WE     (memWe),
        .MEM_ADDRESS(memAddr),
        .MEM_DI     (memDi),
        .MEM_DO     (memDo),
        .INIT_DONE  (initDone)
`ifdef MEM_ARB_STATS_EN
        ,
        .A_GRANT_CNT(aGrantCnt),
        .B_GRANT_CNT(bGrantCnt)
`endif
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural single-port RAM: samples on rising edge while EN is high.
    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = 8'hC3;
        memDo = 8'h00;
    end

    always @(posedge clk) begin
        if (memEn) begin
            if (memWe) ram[memAddr] <= memDi;
            else       memDo <= ram[memAddr];
        end
    end

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives both requesters' inputs at once.
    task automatic applyStimulus(input logic rA, input logic wA, input logic [10:0] adA, input logic [7:0] dA,
                                 input logic rB, input logic wB, input logic [10:0] adB, input logic [7:0] dB);
        aReq = rA; aWe = wA; aAddr = adA; aDi = dA;
        bReq = rB; bWe = wB; bAddr = adB; bDi = dB;
    endtask

    // Watches a full clear sweep after reset release, with A_REQ optionally
    // held high. Returns at posedge+1 of the first cycle with INIT_DONE=1.
    task automatic runSweep(input string tag, input logic holdReq);
        int  writes  = 0;
        int  seqErr  = 0;
        int  ackEarly = 0;
        int  cyc     = 0;
        logic done   = 1'b0;
        logic [10:0] expAddr;
        applyStimulus(holdReq, 1'b0, 11'h000, 8'h00, 1'b0, 1'b0, 11'h000, 8'h00);
        @(negedge clk);
        rstN = 1'b1;
        while (!done && (cyc < 3000)) begin
            @(posedge clk); #1;
            cyc++;
            if (memEn && memWe) begin
                expAddr = writes[10:0];
                if ((memAddr != expAddr) || (memDi != 8'h00)) seqErr++;
                writes++;
            end
            if (initDone) done = 1'b1;
            else if (aAck || bAck) ackEarly++;
        end
        checkOutput({tag, "_done"}, 64'(done), 64'd1);
        checkOutput({tag, "_writes"}, 64'(writes), 64'd2048);
        checkOutput({tag, "_seq"}, 64'(seqErr), 64'd0);
        checkOutput({tag, "_ack_early"}, 64'(ackEarly), 64'd0);
        checkOutput({tag, "_last_addr"}, 64'(memAddr), 64'h7FF);
        checkOutput({tag, "_ack_first"}, 64'(aAck), 64'(holdReq));
        applyStimulus(1'b0, 1'b0, 11'h000, 8'h00, 1'b0, 1'b0, 11'h000, 8'h00);
        #1;
    endtask

    function automatic logic [63:0] allOutputs();
        return 64'({aAck, aDo, aValid, bAck, bDo, bValid, memEn, memWe, memAddr, memDi, initDone});
    endfunction

    initial begin
        logic       bSeen;
        logic       vSeen;
        logic [11:0] grantSeq;
        logic [19:0] validSeq;
        int         dataErr;

        rstN = 1'b0;
        applyStimulus(1'b1, 1'b0, 11'h000, 8'h00, 1'b0, 1'b0, 11'h000, 8'h00);
        #23;
        checkOutput("reset_outputs", allOutputs(), 64'd0);

        // Sweep with A_REQ held high.
        runSweep("clr1", 1'b1);
        checkOutput("idle_ack", 64'(aAck), 64'd0);

        // A writes 0x5A to 0x007, then reads it back on the next grant.
        applyStimulus(1'b1, 1'b1, 11'h007, 8'h5A, 1'b0, 1'b0, 11'h000, 8'h00);
        #1;
        checkOutput("raw_wr_ack", 64'(aAck), 64'd1);
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 11'h007, 8'h00, 1'b0, 1'b0, 11'h000, 8'h00);
        #1;
        checkOutput("raw_rd_ack", 64'(aAck), 64'd1);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 11'h000, 8'h00, 1'b0, 1'b0, 11'h000, 8'h00);
        bSeen = bValid;
        @(posedge clk); #1;
        checkOutput("raw_valid_early", 64'(aValid), 64'd0);
        bSeen = bSeen | bValid;
        @(posedge clk); #1;
        checkOutput("raw_valid", 64'(aValid), 64'd1);
        checkOutput("raw_data", 64'(aDo), 64'h5A);
        bSeen = bSeen | bValid;
        @(posedge clk); #1;
        checkOutput("raw_strobe_end", 64'(aValid), 64'd0);
        checkOutput("raw_do_hold", 64'(aDo), 64'h5A);
        checkOutput("raw_b_quiet", 64'(bSeen | bValid), 64'd0);

        // Pointer now names B: B writes 0xFF to 0x7FF while A reads 0x7FF.
        applyStimulus(1'b1, 1'b0, 11'h7FF, 8'h00, 1'b1, 1'b1, 11'h7FF, 8'hFF);
        #1;
        checkOutput("rr_first_grant", 64'({aAck, bAck}), 64'b01);
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 11'h7FF, 8'h00, 1'b0, 1'b0, 11'h000, 8'h00);
        #1;
        checkOutput("rr_second_grant", 64'({aAck, bAck}), 64'b10);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 11'h000, 8'h00, 1'b0, 1'b0, 11'h000, 8'h00);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("rr_raw_valid", 64'({aValid, bValid}), 64'b10);
        checkOutput("rr_raw_data", 64'(aDo), 64'hFF);

        // Reset one cycle after a read handshake: the read must vanish.
        applyStimulus(1'b1, 1'b0, 11'h007, 8'h00, 1'b0, 1'b0, 11'h000, 8'h00);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 11'h000, 8'h00, 1'b0, 1'b0, 11'h000, 8'h00);
        @(posedge clk); #2;
        rstN = 1'b0;
        #1;
        checkOutput("midrst_outputs", allOutputs(), 64'd0);
        vSeen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            vSeen = vSeen | aValid | bValid;
        end
        checkOutput("midrst_no_valid", 64'(vSeen), 64'd0);
        runSweep("clr2", 1'b0);

        // Seed 0x001/0x002, then both requesters read continuously.
        applyStimulus(1'b1, 1'b1, 11'h001, 8'h11, 1'b0, 1'b0, 11'h000, 8'h00);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 11'h000, 8'h00, 1'b1, 1'b1, 11'h002, 8'h22);
        @(posedge clk); #1;
        grantSeq = '0;
        validSeq = '0;
        dataErr  = 0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            validSeq = {validSeq[17:0], aValid, bValid};
            if (aValid && (aDo != 8'h11)) dataErr++;
            if (bValid && (bDo != 8'h22)) dataErr++;
            if (c < 6) begin
                applyStimulus(1'b1, 1'b0, 11'h001, 8'h00, 1'b1, 1'b0, 11'h002, 8'h00);
                #1;
                grantSeq = {grantSeq[9:0], aAck, bAck};
            end else begin
                applyStimulus(1'b0, 1'b0, 11'h000, 8'h00, 1'b0, 1'b0, 11'h000, 8'h00);
            end
        end
        checkOutput("alt_grants", 64'(grantSeq), 64'b10_01_10_01_10_01);
        checkOutput("alt_valids", 64'(validSeq), 64'b00_00_00_10_01_10_01_10_01_00);
        checkOutput("alt_data", 64'(dataErr), 64'd0);

`ifdef MEM_ARB_STATS_EN
        // Counter saturation: fresh reset, then 70000 A-only handshakes.
        @(negedge clk);
        rstN = 1'b0;
        #1;
        checkOutput("cnt_reset", 64'({aGrantCnt, bGrantCnt}), 64'd0);
        runSweep("clr3", 1'b0);
        checkOutput("cnt_after_clear", 64'({aGrantCnt, bGrantCnt}), 64'd0);
        applyStimulus(1'b1, 1'b0, 11'h010, 8'h00, 1'b0, 1'b0, 11'h000, 8'h00);
        repeat (70000) @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 11'h000, 8'h00, 1'b0, 1'b0, 11'h000, 8'h00);
        checkOutput("cnt_a_sat", 64'(aGrantCnt), 64'hFFFF);
        checkOutput("cnt_b_zero", 64'(bGrantCnt), 64'h0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
